vram_rect_writer: RTL and testbench
===================================

VRAM_RECT_WRITER -- requirements
Module: vram_rect_writer

Interface
REQ-001 The block SHALL have parameter H_PIXELS, default 128, frame width in pixels; it SHALL be a power of two.
REQ-002 The block SHALL have parameter V_PIXELS, default 96, frame height in pixels.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  command strobe, sampled on a rising clk edge.
REQ-006 Port abort  input  1  cancels an in-progress fill.
REQ-007 Port x0  input  7  left column of the rectangle.
REQ-008 Port y0  input  7  top row of the rectangle.
REQ-009 Port width  input  8  rectangle width in pixels, legal range 1..128.
REQ-010 Port height  input  7  rectangle height in pixels, legal range 1..96.
REQ-011 Port color  input  3  fill colour as {red, green, blue}.
REQ-012 Port wr_addr  output  14  VRAM write address, formatted as {row[6:0], col[6:0]}.
REQ-013 Port wr_data  output  3  per-channel write bits as {red, green, blue}; one bit goes to each 1-bit VRAM channel.
REQ-014 Port wr_en  output  1  write enable, shared by all three VRAM channels.
REQ-015 Port busy  output  1  high while a fill is in progress.
REQ-016 Port done  output  1  one-cycle pulse when a fill completes.
REQ-017 Port error  output  1  one-cycle pulse when a command is rejected.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, FILL and FINISH.
REQ-019 In IDLE, start=1 SHALL capture x0, y0, width, height and color into internal registers on the same edge.
- Later changes to these inputs SHALL NOT affect the fill in progress.
REQ-020 A command SHALL be rejected if any of the following holds: width=0, height=0, x0+width>H_PIXELS, or y0+height>V_PIXELS.
- All sums SHALL be computed at 9-bit width so they cannot overflow.
REQ-021 A rejected command SHALL pulse error for 1 cycle, starting the cycle after start, and SHALL leave the FSM in IDLE with no wr_en.
REQ-022 An accepted command SHALL move IDLE->FILL. wr_en=1 SHALL be asserted the cycle after start, with wr_addr={y0,x0} (latency 1).
REQ-023 In FILL, one pixel SHALL be written per cycle in raster order.
- The column increments first.
- At column x0+width-1, the column returns to x0 and the row increments.
REQ-024 wr_data SHALL equal the captured colour throughout FILL.
REQ-025 A fill SHALL produce exactly width*height consecutive cycles with wr_en=1, with no gaps and no repeated addresses.
REQ-026 After the write to {y0+height-1, x0+width-1}, the FSM SHALL go FILL->FINISH.
- In FINISH: done=1, busy=0, wr_en=0 for 1 cycle.
- The FSM then goes FINISH->IDLE.
REQ-027 busy SHALL be 1 exactly in the cycles where wr_en=1.
REQ-028 start asserted in FILL or FINISH SHALL be ignored; it SHALL NOT be queued.
REQ-029 abort=1 in FILL SHALL force wr_en=0 and busy=0 from the next cycle and return the FSM to IDLE without a done pulse.
- The write presented in the cycle abort is sampled SHALL still complete.
REQ-030 abort in IDLE or FINISH SHALL have no effect. If start and abort are both 1 in IDLE, start SHALL win.
REQ-031 A new start SHALL be accepted in the IDLE cycle immediately following FINISH, so back-to-back fills are spaced 2 cycles apart.
REQ-032 Outside FILL, wr_addr and wr_data SHALL hold their last values; downstream logic SHALL qualify them with wr_en.

Reset
REQ-033 reset=0 SHALL immediately and asynchronously set the following values:
- FSM=IDLE
- wr_en=0, busy=0, done=0, error=0
- wr_addr=0, wr_data=0
- all captured registers=0
REQ-034 reset asserted mid-FILL SHALL terminate the fill at once, with no further writes and no done pulse.
REQ-035 After reset is released, the block SHALL accept start on the first rising edge at which reset=1.

Verification
REQ-036 Scenario: start with x0=5, y0=2, w=3, h=2, color=3'b101 -> 6 writes at addresses 261, 262, 263, 389, 390, 391 with wr_data=101; then a done pulse 1 cycle after the last write.
REQ-037 Scenario: full-frame fill with x0=0, y0=0, w=128, h=96 -> 12288 consecutive writes at addresses 0..12287 with the address mapping {row,col}; then a single done pulse.
REQ-038 Scenario: illegal commands x0=120/w=9, then h=0, then y0=90/h=7 -> one error pulse each, zero wr_en cycles, busy stays 0.
REQ-039 Scenario: start at 1x1 with x0=127, y0=95 -> exactly one write at address 12287; done pulses 2 cycles after start.
REQ-040 Scenario: abort on the 4th write of a 4x4 fill -> exactly 4 writes, no done pulse; a next start 1 cycle later is accepted normally.
REQ-041 Scenario: reset=0 asserted asynchronously during a fill, between clock edges -> wr_en and busy drop before the next edge, and no done pulse follows; start pulsed during FILL of a 2x2 fill -> still only 4 writes.

Source files
------------

// File: rtl/vram_rect_writer.sv
// Rectangle fill engine: writes a solid-colour rectangle into a 1-bit-per-channel RGB VRAM, one pixel per cycle.
// Latency: first write one cycle after an accepted start; done pulses one cycle after the last write.
// Backpressure: none; start outside IDLE is dropped (not queued), abort cancels a fill mid-stream.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-low reset
//   start, abort      - command strobe / cancel of an in-progress fill
//   x0, y0            - top-left pixel of the rectangle
//   width, height     - rectangle size (1..H_PIXELS, 1..V_PIXELS)
//   color             - fill colour {red, green, blue}
//   wr_addr, wr_data  - VRAM write address {row, col} and per-channel bits, qualified by wr_en
//   wr_en             - write enable shared by all three channels
//   busy, done, error - fill in progress / fill completed pulse / command rejected pulse
module vram_rect_writer #(
    parameter int H_PIXELS = 128,
    parameter int V_PIXELS = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  x0,
    input  logic [6:0]  y0,
    input  logic [7:0]  width,
    input  logic [6:0]  height,
    input  logic [2:0]  color,
    output logic [13:0] wr_addr,
    output logic [2:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured command. Only an accepted command is captured, so a rejected
    // command leaves the held wr_addr/wr_data of the previous fill untouched.
    logic [6:0] x0_q;
    logic [6:0] y0_q;
    logic [7:0] width_q;
    logic [6:0] height_q;
    logic [2:0] color_q;

    // Raster position of the pixel currently presented on wr_addr.
    logic [6:0] col_q;
    logic [6:0] row_q;

    logic       error_q;

    // Command legality, evaluated on the raw inputs in the start cycle.
    // 9-bit sums: 127 + 128 = 255 fits, so the bound check never wraps.
    logic [8:0] x_end;
    logic [8:0] y_end;
    logic       cmd_ok;

    // Last column/row of the rectangle, also 9 bits wide.
    logic [8:0] last_col;
    logic [8:0] last_row;
    logic       col_last;
    logic       row_last;

    logic       accept;
    logic       reject;
    logic       step;

    assign x_end  = {2'b00, x0} + {1'b0, width};
    assign y_end  = {2'b00, y0} + {2'b00, height};
    assign cmd_ok = (width != 8'd0) && (height != 7'd0) &&
                    (x_end <= 9'(H_PIXELS)) && (y_end <= 9'(V_PIXELS));

    assign last_col = {2'b00, x0_q} + {1'b0, width_q} - 9'd1;
    assign last_row = {2'b00, y0_q} + {2'b00, height_q} - 9'd1;
    assign col_last = ({2'b00, col_q} == last_col);
    assign row_last = ({2'b00, row_q} == last_row);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        step      = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                // start wins over a simultaneous abort: abort is not looked at here.
                if (start) begin
                    if (cmd_ok) begin
                        accept    = 1'b1;
                        state_nxt = FILL;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end

            FILL: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                // The write on the bus this cycle completes regardless of abort;
                // abort only stops the following ones.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (col_last && row_last) begin
                    state_nxt = FINISH;
                end else begin
                    step      = 1'b1;
                end
            end

            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture, raster counters, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0_q     <= 7'd0;
            y0_q     <= 7'd0;
            width_q  <= 8'd0;
            height_q <= 7'd0;
            color_q  <= 3'd0;
            col_q    <= 7'd0;
            row_q    <= 7'd0;
            error_q  <= 1'b0;
        end else begin
            error_q <= reject;
            if (accept) begin
                x0_q     <= x0;
                y0_q     <= y0;
                width_q  <= width;
                height_q <= height;
                color_q  <= color;
                col_q    <= x0;
                row_q    <= y0;
            end else if (step) begin
                // Column first; wrap back to the left edge and drop a row.
                if (col_last) begin
                    col_q <= x0_q;
                    row_q <= row_q + 7'd1;
                end else begin
                    col_q <= col_q + 7'd1;
                end
            end
        end
    end

    // Address and data are straight register outputs, so they hold their
    // last value whenever wr_en is low.
    assign wr_addr = {row_q, col_q};
    assign wr_data = color_q;
    assign error   = error_q;

endmodule

// File: tb/tb_vram_rect_writer.sv
module tb_vram_rect_writer;

    localparam int HP = 128;
    localparam int VP = 96;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [6:0]  x0;
    logic [6:0]  y0;
    logic [7:0]  width;
    logic [6:0]  height;
    logic [2:0]  color;
    logic [13:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        error;

    vram_rect_writer #(.H_PIXELS(HP), .V_PIXELS(VP)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .x0      (x0),
        .y0      (y0),
        .width   (width),
        .height  (height),
        .color   (color),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected record per output cycle; an empty queue means "quiet".
    typedef struct {
        bit en;
        bit bsy;
        bit dn;
        bit er;
        int addr;
        int dat;
    } rec_t;

    rec_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    int n_dn  = 0;
    int n_er  = 0;
    int s_wr, s_dn, s_er;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the output stream must look like for a command.
    function automatic void model_cmd(input int x, input int y, input int w, input int h,
                                      input int c, input int abort_at);
        rec_t r;
        int   n;
        n = 0;
        if (w == 0 || h == 0 || x + w > HP || y + h > VP) begin
            r = '{0, 0, 0, 1, 0, 0};
            exp_q.push_back(r);
            return;
        end
        for (int rr = 0; rr < h; rr++) begin
            for (int cc = 0; cc < w; cc++) begin
                if (abort_at == 0 || n < abort_at) begin
                    r = '{1, 1, 0, 0, (y + rr) * HP + (x + cc), c};
                    exp_q.push_back(r);
                    n++;
                end
            end
        end
        if (abort_at == 0) begin
            r = '{0, 0, 1, 0, 0, 0};
            exp_q.push_back(r);
            r = '{0, 0, 0, 0, 0, 0};
            exp_q.push_back(r);
        end
    endfunction

    // Per-cycle compare, one sample #1 after every rising edge.
    initial begin
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{0, 0, 0, 0, 0, 0};
            chk("wr_en", int'(wr_en), int'(e.en));
            chk("busy",  int'(busy),  int'(e.bsy));
            chk("done",  int'(done),  int'(e.dn));
            chk("error", int'(error), int'(e.er));
            if (e.en) begin
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.dat);
            end
            if (wr_en) n_wr++;
            if (done)  n_dn++;
            if (error) n_er++;
        end
    end

    task automatic wait_drain(input int budget);
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic snap();
        s_wr = n_wr;
        s_dn = n_dn;
        s_er = n_er;
    endtask

    task automatic counts(input string name, input int dw, input int dd, input int de);
        chk({name, "_writes"}, n_wr - s_wr, dw);
        chk({name, "_dones"},  n_dn - s_dn, dd);
        chk({name, "_errors"}, n_er - s_er, de);
    endtask

    // Called at a falling edge; returns one cycle later with inputs scrambled.
    task automatic issue(input int x, input int y, input int w, input int h, input int c,
                         input int abort_at, input bit ab_start);
        wait_drain(20000);
        x0     = x[6:0];
        y0     = y[6:0];
        width  = w[7:0];
        height = h[6:0];
        color  = c[2:0];
        start  = 1'b1;
        abort  = ab_start;
        model_cmd(x, y, w, h, c, abort_at);
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        x0     = 7'($urandom);
        y0     = 7'($urandom);
        width  = 8'($urandom);
        height = 7'($urandom);
        color  = 3'($urandom);
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        x0     = 7'd0;
        y0     = 7'd0;
        width  = 8'd0;
        height = 7'd0;
        color  = 3'd0;

        // Hand-computed pins on the model itself.
        model_cmd(5, 2, 3, 2, 5, 0);
        chk("pin_len", exp_q.size(), 8);
        chk("pin_first", exp_q[0].addr, 261);
        chk("pin_wrap", exp_q[3].addr, 389);
        chk("pin_last", exp_q[5].addr, 391);
        chk("pin_dat", exp_q[5].dat, 5);
        chk("pin_done", int'(exp_q[6].dn), 1);
        exp_q.delete();
        model_cmd(127, 95, 1, 1, 2, 0);
        chk("pin_corner", exp_q[0].addr, 12287);
        exp_q.delete();
        model_cmd(120, 0, 9, 1, 0, 0);
        chk("pin_rej_len", exp_q.size(), 1);
        chk("pin_rej_err", int'(exp_q[0].er), 1);
        exp_q.delete();
        model_cmd(0, 0, 4, 4, 0, 4);
        chk("pin_abort_len", exp_q.size(), 4);
        exp_q.delete();

        // Reset state.
        #12;
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_data", int'(wr_data), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        @(negedge clk);
        reset = 1'b1;

        // Small rectangle with a row wrap; outputs hold afterwards.
        snap();
        issue(5, 2, 3, 2, 5, 0, 0);
        wait_drain(100);
        counts("small", 6, 1, 0);
        chk("hold_addr", int'(wr_addr), 391);
        chk("hold_data", int'(wr_data), 5);

        // Full frame.
        snap();
        issue(0, 0, 128, 96, 6, 0, 0);
        wait_drain(20000);
        counts("frame", 12288, 1, 0);

        // Illegal commands.
        snap();
        issue(120, 0, 9, 1, 1, 0, 0);
        issue(0, 0, 4, 0, 1, 0, 0);
        issue(0, 90, 2, 7, 1, 0, 0);
        wait_drain(100);
        counts("illegal", 0, 0, 3);
        chk("rej_hold_addr", int'(wr_addr), 12287);

        // Bottom-right 1x1, then a back-to-back fill in the IDLE cycle after FINISH.
        snap();
        issue(127, 95, 1, 1, 2, 0, 0);
        issue(0, 0, 2, 1, 7, 0, 0);
        wait_drain(100);
        counts("b2b", 3, 2, 0);

        // Abort on the 4th write, next start one cycle later.
        snap();
        issue(10, 10, 4, 4, 3, 4, 0);
        issue(0, 1, 2, 2, 1, 0, 0);
        wait_drain(100);
        counts("abort", 8, 1, 0);

        // start and abort together in IDLE: start wins.
        snap();
        issue(3, 3, 2, 2, 4, 0, 1);
        wait_drain(100);
        counts("start_abort", 4, 1, 0);

        // Asynchronous reset between edges during a fill.
        snap();
        issue(20, 20, 4, 4, 1, 0, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("async_wr_en", int'(wr_en), 0);
        chk("async_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        counts("reset_mid", 4, 0, 0);

        // Start accepted on the first edge after release.
        snap();
        reset = 1'b1;
        issue(1, 1, 1, 1, 3, 0, 0);
        wait_drain(100);
        counts("post_reset", 1, 1, 0);

        // start pulsed during FILL is ignored.
        snap();
        issue(30, 40, 2, 2, 2, 0, 0);
        start  = 1'b1;
        x0     = 7'd0;
        y0     = 7'd0;
        width  = 8'd1;
        height = 7'd1;
        @(negedge clk);
        start  = 1'b0;
        wait_drain(100);
        repeat (3) @(negedge clk);
        counts("start_in_fill", 4, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
